// File: rtl/plru_tree_victim_if.sv
// Request/response bundle between the TLB lookup/refill controller and the tree-PLRU victim engine.
// The controller is the master; the engine is the slave. Responses are registered, with no backpressure.
interface plru_tree_victim_if #(
    parameter int WAYS = 32
);
    localparam int IW = $clog2(WAYS);

    logic            flush;
    logic            access;
    logic [IW-1:0]   access_idx;
    logic            compare;
    logic [WAYS-1:0] valid_vec;
    logic [WAYS-1:0] lock_vec;
    logic [IW-1:0]   victim_idx;
    logic            victim_valid;
    logic            victim_none;

    modport master (
        output flush, access, access_idx, compare, valid_vec, lock_vec,
        input  victim_idx, victim_valid, victim_none
    );

    modport slave (
        input  flush, access, access_idx, compare, valid_vec, lock_vec,
        output victim_idx, victim_valid, victim_none
    );
endinterface

// File: rtl/plru_tree_victim.sv
// Tree pseudo-LRU victim picker. It prefers free entries and never selects pinned entries.
// Latency is one cycle from compare to victim_valid. There is no backpressure: every compare yields one pulse.
module plru_tree_victim #(
    parameter  int WAYS = 32,
    localparam int IW   = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    plru_tree_victim_if.slave bus
);

    // Heap-indexed tree: node n has children 2n and 2n+1. The leaf for way i is WAYS+i.
    logic [WAYS-1:1] tree_q, tree_d;
    logic [IW-1:0]   victim_idx_q, victim_idx_d;
    logic            victim_valid_q, victim_valid_d;
    logic            victim_none_q, victim_none_d;

    logic [IW-1:0]   sel_idx;
    logic            sel_none;

    function automatic int node_depth(input int n);
        return $clog2(n + 1) - 1;
    endfunction

    always_comb begin : victim_select
        logic [2*WAYS-1:1] all_lock;
        logic [2*WAYS-1:1] reach;
        logic              go_right;
        logic              free_hit;
        logic [IW-1:0]     free_idx;
        logic [IW-1:0]     walk_idx;

        all_lock = '0;
        reach    = '0;
        go_right = 1'b0;
        free_hit = 1'b0;
        free_idx = '0;
        walk_idx = '0;
        sel_idx  = '0;
        sel_none = 1'b0;

        for (int i = 0; i < WAYS; i++) begin
            all_lock[WAYS+i] = bus.lock_vec[i];
        end
        for (int n = WAYS - 1; n >= 1; n--) begin
            all_lock[n] = all_lock[2*n] & all_lock[2*n+1];
        end

        // Follow the node bits. Detour only when the preferred subtree is fully pinned.
        reach[1] = 1'b1;
        for (int n = 1; n < WAYS; n++) begin
            go_right       = tree_q[n] ? !all_lock[2*n+1] : all_lock[2*n];
            reach[2*n]     = reach[n] & ~go_right;
            reach[2*n+1]   = reach[n] & go_right;
        end
        for (int i = 0; i < WAYS; i++) begin
            if (reach[WAYS+i]) begin
                walk_idx = IW'(i);
            end
        end

        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid_vec[i] && !bus.lock_vec[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end

        sel_none = all_lock[1];
        if (sel_none) begin
            sel_idx = '0;
        end else if (free_hit) begin
            sel_idx = free_idx;
        end else begin
            sel_idx = walk_idx;
        end
    end

    always_comb begin : tree_update
        logic [IW:0] leaf;

        leaf   = {1'b1, bus.access_idx};
        tree_d = tree_q;
        if (bus.flush) begin
            tree_d = '0;
        end else if (bus.access) begin
            // A node is on the path if the leaf's ancestor at its depth is that node. Each such node points away from the branch taken.
            for (int n = 1; n < WAYS; n++) begin
                if ((leaf >> (IW - node_depth(n))) == (IW+1)'(n)) begin
                    tree_d[n] = ~bus.access_idx[IW-1-node_depth(n)];
                end
            end
        end
    end

    always_comb begin : out_next
        victim_valid_d = bus.compare;
        victim_idx_d   = victim_idx_q;
        victim_none_d  = victim_none_q;
        if (bus.compare) begin
            victim_idx_d  = sel_idx;
            victim_none_d = sel_none;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tree_q         <= '0;
            victim_idx_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_none_q  <= 1'b0;
        end else begin
            tree_q         <= tree_d;
            victim_idx_q   <= victim_idx_d;
            victim_valid_q <= victim_valid_d;
            victim_none_q  <= victim_none_d;
        end
    end

    assign bus.victim_idx   = victim_idx_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_none  = victim_none_q;

endmodule

// File: tb/tb_plru_tree_victim.sv
// Directed bench for plru_tree_victim. WAYS=8 is driven from a vector table.
// WAYS=32 and WAYS=2 are driven by short hand-written sequences.
module tb_plru_tree_victim;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plru_tree_victim_if #(.WAYS(8))  b8 ();
    plru_tree_victim_if #(.WAYS(32)) b32 ();
    plru_tree_victim_if #(.WAYS(2))  b2 ();

    plru_tree_victim #(.WAYS(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
    plru_tree_victim #(.WAYS(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
    plru_tree_victim #(.WAYS(2))  u2  (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       acc;
        logic [2:0] aidx;
        logic       cmp;
        logic [7:0] vv;
        logic [7:0] lv;
        logic       e_vld;
        logic [2:0] e_idx;
        logic       e_none;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic a, input logic [2:0] ai,
                                input logic c, input logic [7:0] vv, input logic [7:0] lv,
                                input logic ev, input logic [2:0] ei, input logic en);
        vec_t v;
        v.rst = r;  v.flush = f; v.acc = a;  v.aidx = ai; v.cmp = c;
        v.vv  = vv; v.lv = lv;   v.e_vld = ev; v.e_idx = ei; v.e_none = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {b8.flush, b8.access, b8.access_idx, b8.compare}    = '0;
        {b32.flush, b32.access, b32.access_idx, b32.compare} = '0;
        {b2.flush, b2.access, b2.access_idx, b2.compare}    = '0;
        b8.valid_vec  = '1; b8.lock_vec  = '0;
        b32.valid_vec = '1; b32.lock_vec = '0;
        b2.valid_vec  = '1; b2.lock_vec  = '0;
        repeat (3) @(posedge clk);

        //                r  f  a  ai c  vv     lv     ev ei en
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0)); // reset state
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0)); // pulse drops, idx holds
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 4, 0));
        for (int w = 0; w < 8; w++)
            tbl.push_back(mk(0, 0, 1, 3'(w), 0, 8'hFF, 8'h00, 0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0)); // all nodes back to 0
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFB, 8'h00, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFE, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h0F, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'hFF, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 1)); // none holds
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 8'hFF, 8'h00, 1, 0, 0)); // access+compare: pre-update
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 8'hFF, 8'h00, 0, 4, 0)); // flush discards access
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 8'hFF, 8'h00, 1, 4, 0)); // flush+compare: pre-flush
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFB, 8'h00, 1, 2, 0)); // invalid beats non-zero tree
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 4, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8'hFF, 8'h00, 0, 0, 0)); // rst kills pulse
        tbl.push_back(mk(0, 0, 0, 0, 1, 8'hFF, 8'h00, 1, 0, 0));

        foreach (tbl[k]) begin
            @(negedge clk);
            rst           = tbl[k].rst;
            b8.flush      = tbl[k].flush;
            b8.access     = tbl[k].acc;
            b8.access_idx = tbl[k].aidx;
            b8.compare    = tbl[k].cmp;
            b8.valid_vec  = tbl[k].vv;
            b8.lock_vec   = tbl[k].lv;
            settle();
            chk($sformatf("w8.v%0d.valid", k), 32'(b8.victim_valid), 32'(tbl[k].e_vld));
            chk($sformatf("w8.v%0d.idx", k),   32'(b8.victim_idx),   32'(tbl[k].e_idx));
            chk($sformatf("w8.v%0d.none", k),  32'(b8.victim_none),  32'(tbl[k].e_none));
        end
        @(negedge clk);
        rst = 1'b0;
        {b8.flush, b8.access, b8.compare} = '0;

        // WAYS=32: access 0 then compare gives 16; access 16 then compare gives 8.
        b32.access = 1'b1; b32.access_idx = 5'd0;
        settle();
        @(negedge clk); b32.access = 1'b0; b32.compare = 1'b1;
        settle();
        chk("w32.acc0.valid", 32'(b32.victim_valid), 32'd1);
        chk("w32.acc0.idx",   32'(b32.victim_idx),   32'd16);
        @(negedge clk); b32.compare = 1'b0; b32.access = 1'b1; b32.access_idx = 5'd16;
        settle();
        chk("w32.idle.valid", 32'(b32.victim_valid), 32'd0);
        @(negedge clk); b32.access = 1'b0; b32.compare = 1'b1;
        settle();
        chk("w32.acc16.idx",  32'(b32.victim_idx),   32'd8);
        @(negedge clk); b32.compare = 1'b0;

        // WAYS=2: a single node bit.
        b2.compare = 1'b1;
        settle();
        chk("w2.reset.idx", 32'(b2.victim_idx), 32'd0);
        @(negedge clk); b2.compare = 1'b0; b2.access = 1'b1; b2.access_idx = 1'b0;
        settle();
        @(negedge clk); b2.access = 1'b0; b2.compare = 1'b1;
        settle();
        chk("w2.acc0.idx", 32'(b2.victim_idx), 32'd1);
        @(negedge clk); b2.lock_vec = 2'b10;
        settle();
        chk("w2.lock1.idx",  32'(b2.victim_idx),  32'd0);
        chk("w2.lock1.none", 32'(b2.victim_none), 32'd0);
        @(negedge clk); b2.lock_vec = 2'b11;
        settle();
        chk("w2.lockall.none",  32'(b2.victim_none),  32'd1);
        chk("w2.lockall.idx",   32'(b2.victim_idx),   32'd0);
        chk("w2.lockall.valid", 32'(b2.victim_valid), 32'd1);
        @(negedge clk); b2.compare = 1'b0; b2.lock_vec = 2'b00; b2.access = 1'b1; b2.access_idx = 1'b1;
        settle();
        @(negedge clk); b2.access = 1'b0; b2.compare = 1'b1;
        settle();
        chk("w2.acc1.idx", 32'(b2.victim_idx), 32'd0);
        @(negedge clk); b2.compare = 1'b0;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plru_tree_victim.md
Name: plru_tree_victim

Overview:
- Parametrised tree pseudo-LRU replacement engine for fully-associative TLB/cache arrays with WAYS entries.
- Tracks use order in a binary tree of WAYS-1 state bits and returns one registered victim index per request.
- Victim selection prefers invalid entries and never picks locked (pinned) entries.
- Instantiated beside the ITLB/DTLB tag arrays and driven by the lookup/refill controller.

Parameters:
- WAYS, 32, number of entries; power of two, 2..64.
- IW, $clog2(WAYS), index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  clears all tree state to 0; does not affect outputs.
- access  input  1  hit/refill strobe; updates the tree for access_idx.
- access_idx  input  IW  entry just used.
- compare  input  1  victim request strobe.
- valid_vec  input  WAYS  per-entry valid bits from the tag array.
- lock_vec  input  WAYS  per-entry pin bits; a set bit excludes that entry from victim selection.
- victim_idx  output  IW  registered victim index.
- victim_valid  output  1  one-cycle pulse, high the cycle after compare.
- victim_none  output  1  registered; high when every entry is locked.

Behaviour:
- Tree state
  - Bits are heap-indexed as node[1..WAYS-1]; node n has children 2n and 2n+1.
  - Leaf for way i is WAYS+i.
  - node=0: the LRU side is left (lower indices). node=1: the LRU side is right.
- Access update (edge with access=1)
  - Every node on the path from the root to leaf WAYS+access_idx is set to point away from the accessed side.
  - Came from the left child: write 1. Came from the right child: write 0.
  - Nodes off the path are unchanged.
- Victim selection (combinational, from the current tree state and inputs)
  - Priority 1: the lowest-index way with valid_vec=0 and lock_vec=0.
  - Priority 2: tree walk from the root following the node bits. At each node, if every way in the indicated subtree is locked, take the other subtree.
  - If every way is locked: victim_none=1, victim_idx=0.
- Output register
  - On an edge with compare=1: victim_idx and victim_none load the selection, and victim_valid=1 for exactly one cycle.
  - With compare=0: victim_valid=0, and victim_idx/victim_none hold their values.
  - Latency is 1 cycle. Back-to-back compares give back-to-back pulses.
- Simultaneous access and compare
  - The victim is computed from the pre-update tree.
  - The tree update lands on the same edge.
- Priority of events
  - rst > flush > access.
  - flush with access on the same edge: the tree ends all-0 and the access is discarded.
  - flush does not block a compare on the same edge; the victim uses the pre-flush state.
- Reset
  - All tree bits 0; victim_idx=0; victim_valid=0; victim_none=0.
  - Reset asserted mid-operation suppresses any pending pulse: victim_valid is 0 on the edge after rst.
- Out-of-range access_idx cannot occur, because WAYS is a power of two.
- valid_vec and lock_vec are sampled only on compare edges. They must be stable in the cycle compare is high.

Test Plan:
- WAYS=8, after reset, valid_vec=FF, lock_vec=00: compare → next cycle victim_valid=1, victim_idx=0, victim_none=0. Following cycle victim_valid=0 and victim_idx holds 0.
- WAYS=8, reset, access way 0, then compare (valid FF, lock 00) → victim_idx=4. Then access ways 0..7 in order, compare → victim_idx=0.
- Invalid priority: valid_vec=FB, lock_vec=00, any tree state → victim_idx=2. valid_vec=FE with lock_vec=01 → way 0 skipped; from reset state, victim_idx=1.
- Locking: after reset, valid FF, lock_vec=0F → victim_idx=4. lock_vec=FF → victim_none=1, victim_idx=0, victim_valid still pulses.
- Simultaneous events: after reset, access way 0 and compare on the same edge → victim_idx=0 (pre-update). Next compare → 4. Access with flush on the same edge → next compare returns 0.
- Reset mid-op: compare and rst on the same edge → victim_valid=0, victim_idx=0. Repeat the second scenario with WAYS=32 (access 0 → victim 16) and WAYS=2 (access 0 → victim 1).
